mem_wb_skid: RTL and testbench

Parametrised MEM→WB pipeline stage. Replaces the plain stall-only register with a 2-entry ready/valid skid buffer, a synchronous flush, and x0-write squashing. It also provides a combinational forwarding lookup across both held entries. It sits between the MEM stage and the register-file write port, and is the template for other ready/valid stage registers.

---
 rtl/mem_wb_skid_pkg.sv | 26 ++
 rtl/mem_wb_skid_if.sv | 29 ++
 rtl/mem_wb_skid_wb_entry_reg.sv | 49 ++++
 rtl/mem_wb_skid.sv | 147 ++++++++++++++
 tb/tb_mem_wb_skid.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wb_skid_pkg.sv
// Shared definitions for the MEM->WB skid stage.
//   - reset / write-enable encodings and zero constants
//   - wb_entry_t: one held write-back entry at the default widths
//   - state_e: buffer fill state (empty, one entry, two entries)
package mem_wb_skid_pkg;

  localparam logic        RstEnable    = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic [4:0]  NOPRegAddr   = 5'b00000;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  typedef struct packed {
    logic        valid;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_wb_skid_if.sv
// Ready/valid bundle between the MEM stage, this stage register and write-back.
//   in_*  : MEM result offered to the stage (in_ready driven by the stage)
//   out_* : handshake toward write-back, wb_* carry the held entry
// Modports: master = surrounding pipeline, slave = the stage register.
interface mem_wb_skid_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_wd;
  logic              in_wreg;
  logic [DATA_W-1:0] in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;

  modport master (
    output in_valid, in_wd, in_wreg, in_wdata, out_ready,
    input  in_ready, out_valid, wb_wd, wb_wreg, wb_wdata
  );

  modport slave (
    input  in_valid, in_wd, in_wreg, in_wdata, out_ready,
    output in_ready, out_valid, wb_wd, wb_wreg, wb_wdata
  );
endinterface

// File: rtl/mem_wb_skid_wb_entry_reg.sv
// Single write-back entry register.
//   clk          : clock
//   clr          : clear entry (valid and all fields to zero); wins over load
//   load         : capture d_* and mark the entry valid
//   d_wd/wreg/wdata : entry fields to load
//   q_valid/wd/wreg/wdata : held entry; fields read zero while invalid
module wb_entry_reg
  import mem_wb_skid_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              load,
  input  logic [ADDR_W-1:0] d_wd,
  input  logic              d_wreg,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              q_valid,
  output logic [ADDR_W-1:0] q_wd,
  output logic              q_wreg,
  output logic [DATA_W-1:0] q_wdata
);

  logic              valid_q;
  logic [ADDR_W-1:0] wd_q;
  logic              wreg_q;
  logic [DATA_W-1:0] wdata_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      valid_q <= 1'b0;
      wd_q    <= '0;
      wreg_q  <= WriteDisable;
      wdata_q <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      wd_q    <= d_wd;
      wreg_q  <= d_wreg;
      wdata_q <= d_wdata;
    end
  end

  assign q_valid = valid_q;
  assign q_wd    = wd_q;
  assign q_wreg  = wreg_q;
  assign q_wdata = wdata_q;

endmodule

// File: rtl/mem_wb_skid.sv
// MEM->WB stage register: 2-entry ready/valid skid buffer with flush,
// x0-write squashing and a combinational forwarding lookup.
//   clk, rst   : clock, synchronous active-high reset
//   lock       : stall vector; lock[LOCK_BIT] blocks acceptance only
//   flush      : drops both held entries at the next edge
//   bus        : in_* from MEM, out_*/wb_* toward the register file
//   fwd_addr   : lookup address; fwd_hit/fwd_data give the newest match
//   occupancy  : number of held entries (0..2)
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned LOCK_W    = 5,
  parameter int unsigned LOCK_BIT  = 4,
  parameter bit          SQUASH_X0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LOCK_W-1:0] lock,
  input  logic              flush,
  mem_wb_skid_if.slave      bus,
  input  logic [ADDR_W-1:0] fwd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occupancy
);

  state_e state_q, state_d;

  logic              m_valid, m_wreg, m_load, m_clr, m_from_s;
  logic [ADDR_W-1:0] m_wd, m_d_wd;
  logic [DATA_W-1:0] m_wdata, m_d_wdata;
  logic              m_d_wreg;
  logic              s_valid, s_wreg, s_load, s_clr;
  logic [ADDR_W-1:0] s_wd;
  logic [DATA_W-1:0] s_wdata;
  logic              in_wreg_st, accept, pop, s_hit, m_hit, fwd_x0;

  assign bus.in_ready = (rst != RstEnable) & ~flush & ~s_valid & ~lock[LOCK_BIT];
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = m_valid & bus.out_ready;
  assign in_wreg_st   = bus.in_wreg & ~(SQUASH_X0 && (bus.in_wd == '0));

  // M either takes the incoming entry or is refilled from S when draining FULL.
  assign m_d_wd    = m_from_s ? s_wd    : bus.in_wd;
  assign m_d_wreg  = m_from_s ? s_wreg  : in_wreg_st;
  assign m_d_wdata = m_from_s ? s_wdata : bus.in_wdata;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) state_q <= StEmpty;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    m_load    = 1'b0;
    m_clr     = 1'b0;
    m_from_s  = 1'b0;
    s_load    = 1'b0;
    s_clr     = 1'b0;
    occupancy = 2'd0;
    unique case (state_q)
      StEmpty: occupancy = 2'd0;
      StOne:   occupancy = 2'd1;
      StFull:  occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
    if ((rst == RstEnable) || flush) begin
      m_clr   = 1'b1;
      s_clr   = 1'b1;
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            m_load  = 1'b1;
            state_d = StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            m_load = 1'b1;
          end else if (accept) begin
            s_load  = 1'b1;
            state_d = StFull;
          end else if (pop) begin
            m_clr   = 1'b1;
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            m_load   = 1'b1;
            m_from_s = 1'b1;
            s_clr    = 1'b1;
            state_d  = StOne;
          end
        end
        default: begin
          m_clr   = 1'b1;
          s_clr   = 1'b1;
          state_d = StEmpty;
        end
      endcase
    end
  end

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_main (
    .clk     (clk),
    .clr     (m_clr),
    .load    (m_load),
    .d_wd    (m_d_wd),
    .d_wreg  (m_d_wreg),
    .d_wdata (m_d_wdata),
    .q_valid (m_valid),
    .q_wd    (m_wd),
    .q_wreg  (m_wreg),
    .q_wdata (m_wdata)
  );

  wb_entry_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_skid (
    .clk     (clk),
    .clr     (s_clr),
    .load    (s_load),
    .d_wd    (bus.in_wd),
    .d_wreg  (in_wreg_st),
    .d_wdata (bus.in_wdata),
    .q_valid (s_valid),
    .q_wd    (s_wd),
    .q_wreg  (s_wreg),
    .q_wdata (s_wdata)
  );

  assign bus.out_valid = m_valid;
  assign bus.wb_wd     = m_wd;
  assign bus.wb_wreg   = m_wreg & m_valid;
  assign bus.wb_wdata  = m_wdata;

  // S is the newer entry, so it shadows M on an address match.
  assign fwd_x0   = SQUASH_X0 && (fwd_addr == '0);
  assign s_hit    = s_valid & s_wreg & (s_wd == fwd_addr) & ~fwd_x0;
  assign m_hit    = m_valid & m_wreg & (m_wd == fwd_addr) & ~fwd_x0;
  assign fwd_hit  = s_hit | m_hit;
  assign fwd_data = s_hit ? s_wdata : (m_hit ? m_wdata : '0);

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  lock;
  logic        flush;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [1:0]  occupancy;

  mem_wb_skid_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  mem_wb_skid dut (
    .clk       (clk),
    .rst       (rst),
    .lock      (lock),
    .flush     (flush),
    .bus       (bus),
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  ent_t q[$];
  bit   known = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the stage is a FIFO of depth 2 seen through its head entry.
  task automatic model_check();
    logic        exp_ready, exp_hit;
    logic [31:0] exp_fdata;
    ent_t        h;
    exp_ready = !rst && !flush && (q.size() < 2) && !lock[4];
    check_val("in_ready", bus.in_ready, exp_ready);
    if (!known) return;
    check_val("occupancy", occupancy, q.size());
    check_val("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) h = q[0];
    else begin h.wd = 0; h.wreg = 0; h.wdata = 0; end
    check_val("wb_wd", bus.wb_wd, h.wd);
    check_val("wb_wreg", bus.wb_wreg, h.wreg);
    check_val("wb_wdata", bus.wb_wdata, h.wdata);
    exp_hit = 0;
    exp_fdata = 0;
    if (fwd_addr != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!exp_hit && q[i].wreg && q[i].wd == fwd_addr) begin
          exp_hit = 1;
          exp_fdata = q[i].wdata;
        end
      end
    end
    check_val("fwd_hit", fwd_hit, exp_hit);
    check_val("fwd_data", fwd_data, exp_fdata);
  endtask

  task automatic settle();
    #1;
    model_check();
  endtask

  task automatic advance();
    bit   acc, pp;
    ent_t e;
    acc = bus.in_valid && !rst && !flush && (q.size() < 2) && !lock[4];
    pp  = (q.size() > 0) && bus.out_ready;
    e.wd = bus.in_wd;
    e.wreg = bus.in_wreg && (bus.in_wd != 0);
    e.wdata = bus.in_wdata;
    @(posedge clk);
    if (rst) begin
      q.delete();
      known = 1;
    end else if (known) begin
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic drive(input logic v, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] data, input logic rdy);
    bus.in_valid = v;
    bus.in_wd = wd;
    bus.in_wreg = wreg;
    bus.in_wdata = data;
    bus.out_ready = rdy;
  endtask

  int ov_cnt;

  initial begin
    rst = 1; flush = 0; lock = 0; fwd_addr = 0;
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    advance();
    settle();
    check_val("rst_in_ready", bus.in_ready, 0);
    check_val("rst_occupancy", occupancy, 0);
    advance();
    rst = 0;

    // Single transfer, one cycle of latency.
    drive(1, 3, 1, 32'hDEADBEEF, 1);
    settle();
    check_val("ready_after_rst", bus.in_ready, 1);
    advance();
    drive(0, 0, 0, 0, 1);
    settle();
    check_val("t1_out_valid", bus.out_valid, 1);
    check_val("t1_wd", bus.wb_wd, 3);
    check_val("t1_wdata", bus.wb_wdata, 32'hDEADBEEF);
    check_val("t1_occ", occupancy, 1);
    advance();

    // Fill with back-pressure, then drain in order.
    drive(1, 1, 1, 32'h1, 0); tick();
    drive(1, 2, 1, 32'h2, 0); tick();
    drive(0, 0, 0, 0, 0);
    settle();
    check_val("full_occ", occupancy, 2);
    check_val("full_ready", bus.in_ready, 0);
    advance();
    drive(0, 0, 0, 0, 1);
    settle(); check_val("drain1_wd", bus.wb_wd, 1); advance();
    settle(); check_val("drain2_wd", bus.wb_wd, 2); advance();
    settle();
    check_val("drained_occ", occupancy, 0);
    check_val("drained_wdata", bus.wb_wdata, 0);
    advance();

    // Streaming at full rate.
    ov_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1, 5'(i + 1), 1, 32'(i * 16 + 3), 1);
      else drive(0, 0, 0, 0, 1);
      settle();
      check_val("stream_occ_le1", occupancy <= 1, 1);
      advance();
      if (bus.out_valid) ov_cnt++;
    end
    check_val("stream_count", ov_cnt, 8);
    drive(0, 0, 0, 0, 1); tick();

    // Forwarding priority with both entries targeting the same register.
    drive(1, 5, 1, 32'h11, 0); tick();
    drive(1, 5, 1, 32'h22, 0); tick();
    drive(0, 0, 0, 0, 0);
    fwd_addr = 5;
    settle();
    check_val("fwd5_hit", fwd_hit, 1);
    check_val("fwd5_data", fwd_data, 32'h22);
    fwd_addr = 6;
    settle();
    check_val("fwd6_hit", fwd_hit, 0);
    check_val("fwd6_data", fwd_data, 0);
    // Flush while full and offered a new entry.
    flush = 1;
    drive(1, 9, 1, 32'h99, 0);
    tick();
    flush = 0;
    drive(0, 0, 0, 0, 0);
    settle();
    check_val("flush_occ", occupancy, 0);
    check_val("flush_ov", bus.out_valid, 0);
    advance();

    // x0 write squash.
    drive(1, 0, 1, 32'h7, 1); tick();
    drive(0, 0, 0, 0, 1);
    fwd_addr = 0;
    settle();
    check_val("x0_ov", bus.out_valid, 1);
    check_val("x0_wreg", bus.wb_wreg, 0);
    check_val("x0_fwd", fwd_hit, 0);
    advance();

    // Lock blocks acceptance but not draining.
    drive(1, 4, 1, 32'h44, 0); tick();
    lock = 5'b10000;
    drive(1, 6, 1, 32'h66, 1);
    settle();
    check_val("lock_ready", bus.in_ready, 0);
    advance();
    settle();
    check_val("lock_drained", occupancy, 0);
    advance();
    lock = 0;

    // Randomised traffic against the FIFO model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      lock  = ($urandom_range(0, 4) == 0) ? 5'b10000 : 5'($urandom_range(0, 15));
      fwd_addr = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom),
            $urandom, $urandom_range(0, 2) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
